// File: rtl/avalon_param_interval_timer_if.sv
// Avalon-MM slave bus bundle for the interval timer.
// Master drives address/control/data; the slave returns readdata.
interface avalon_param_interval_timer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_param_interval_timer.sv
// Parametrised Avalon-MM interval timer: prescaler, down-counter,
// sticky timeout flag, timeout pulse, snapshot and saturating count.
module avalon_param_interval_timer #(
  parameter int COUNT_WIDTH = 32,
  parameter logic [COUNT_WIDTH-1:0] RESET_PERIOD =
    COUNT_WIDTH'(49999),
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  avalon_param_interval_timer_if.slave bus,
  output logic irq,
  output logic timeout_pulse
);
  localparam int CW = COUNT_WIDTH;
  localparam int PW = PRESCALE_WIDTH;
  localparam bit HAS_HI = (CW > 32);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PER_L   = 3'd2;
  localparam logic [2:0] A_PER_H   = 3'd3;
  localparam logic [2:0] A_SNAP_L  = 3'd4;
  localparam logic [2:0] A_SNAP_H  = 3'd5;
  localparam logic [2:0] A_PRESC   = 3'd6;
  localparam logic [2:0] A_TOCNT   = 3'd7;

  logic [CW-1:0] counter;
  logic [CW-1:0] period;
  logic [CW-1:0] period_nxt;
  logic [CW-1:0] snapshot;
  logic [PW-1:0] prescale;
  logic [PW-1:0] prescale_cnt;
  logic [15:0]   tocount;
  logic          ito;
  logic          cont;
  logic          pulse_en;
  logic          to;
  logic          run;

  logic          wr;
  logic          lo_wr;
  logic          hi_wr;
  logic          per_wr;
  logic          ctl_wr;
  logic          start;
  logic          stop;
  logic          tick;
  logic          tmo;
  logic [63:0]   period64;
  logic [63:0]   snap64;
  logic [31:0]   rd_nxt;

  assign wr     = bus.chipselect & ~bus.write_n;
  assign lo_wr  = wr && (bus.address == A_PER_L);
  assign hi_wr  = wr && (bus.address == A_PER_H) && HAS_HI;
  assign per_wr = lo_wr | hi_wr;
  assign ctl_wr = wr && (bus.address == A_CONTROL);
  assign start  = ctl_wr & bus.writedata[2];
  assign stop   = ctl_wr & bus.writedata[3];

  assign tick = run && (prescale_cnt == prescale);
  assign tmo  = tick && (counter == '0);

  assign irq = to & ito;

  assign period64 = 64'(period);
  assign snap64   = 64'(snapshot);

  // Merge the written word into the period so a partial
  // 64-bit update reloads the counter with the combined value.
  always_comb begin
    period_nxt = period;
    for (int i = 0; i < CW; i++) begin
      if ((i < 32) ? lo_wr : hi_wr)
        period_nxt[i] = bus.writedata[i % 32];
    end
  end

  always_comb begin
    rd_nxt = '0;
    unique case (bus.address)
      A_STATUS:  rd_nxt = {30'd0, run, to};
      A_CONTROL: rd_nxt = {27'd0, pulse_en, 2'd0, cont, ito};
      A_PER_L:   rd_nxt = period64[31:0];
      A_PER_H:   rd_nxt = period64[63:32];
      A_SNAP_L:  rd_nxt = snap64[31:0];
      A_SNAP_H:  rd_nxt = snap64[63:32];
      A_PRESC:   rd_nxt = 32'(prescale);
      A_TOCNT:   rd_nxt = {16'd0, tocount};
      default:   rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period   <= RESET_PERIOD;
      prescale <= '0;
      ito      <= 1'b0;
      cont     <= 1'b0;
      pulse_en <= 1'b0;
      snapshot <= '0;
    end else begin
      if (per_wr)
        period <= period_nxt;
      if (wr && (bus.address == A_PRESC))
        prescale <= bus.writedata[PW-1:0];
      if (ctl_wr) begin
        ito      <= bus.writedata[0];
        cont     <= bus.writedata[1];
        pulse_en <= bus.writedata[4];
      end
      if (wr && ((bus.address == A_SNAP_L) ||
                 (bus.address == A_SNAP_H)))
        snapshot <= counter;
    end
  end

  // A period write overrides any tick or strobe in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= RESET_PERIOD;
      prescale_cnt <= '0;
      run          <= 1'b0;
    end else if (per_wr) begin
      counter      <= period_nxt;
      prescale_cnt <= '0;
      run          <= 1'b0;
    end else begin
      if (tick) begin
        prescale_cnt <= '0;
        counter      <= tmo ? period : counter - CW'(1);
      end else if (run) begin
        prescale_cnt <= prescale_cnt + PW'(1);
      end
      if (start) begin
        run <= 1'b1;
        if (!run)
          prescale_cnt <= '0;
      end else if (stop) begin
        run <= 1'b0;
      end else if (tmo && !cont) begin
        run <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to            <= 1'b0;
      tocount       <= 16'd0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= tmo & pulse_en;
      if (tmo)
        to <= 1'b1;
      else if (wr && (bus.address == A_STATUS))
        to <= 1'b0;
      if (wr && (bus.address == A_TOCNT))
        tocount <= tmo ? 16'd1 : 16'd0;
      else if (tmo && (tocount != 16'hFFFF))
        tocount <= tocount + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bus.readdata <= '0;
    else
      bus.readdata <= rd_nxt;
  end
endmodule

// File: tb/tb_avalon_param_interval_timer.sv
// Self-checking bench for avalon_param_interval_timer: default,
// 40-bit and 16-bit builds, read scoreboard plus cycle sequences.
module tb_avalon_param_interval_timer;
  logic clk;
  logic reset_n;
  logic irq, tp;
  logic irq40, tp40;
  logic irq16, tp16;

  avalon_param_interval_timer_if bus ();
  avalon_param_interval_timer_if bus40 ();
  avalon_param_interval_timer_if bus16 ();

  avalon_param_interval_timer dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .irq(irq), .timeout_pulse(tp)
  );

  avalon_param_interval_timer #(.COUNT_WIDTH(40)) dut40 (
    .clk(clk), .reset_n(reset_n), .bus(bus40),
    .irq(irq40), .timeout_pulse(tp40)
  );

  avalon_param_interval_timer #(.COUNT_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .bus(bus16),
    .irq(irq16), .timeout_pulse(tp16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t rst_vecs[8];

  task automatic check(string name, logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(int d, logic [2:0] a, logic cs,
                       logic wn, logic [31:0] wd);
    case (d)
      0: begin
        bus.address = a; bus.chipselect = cs;
        bus.write_n = wn; bus.writedata = wd;
      end
      1: begin
        bus40.address = a; bus40.chipselect = cs;
        bus40.write_n = wn; bus40.writedata = wd;
      end
      default: begin
        bus16.address = a; bus16.chipselect = cs;
        bus16.write_n = wn; bus16.writedata = wd;
      end
    endcase
  endtask

  function automatic logic [31:0] rdata(int d);
    case (d)
      0:       return bus.readdata;
      1:       return bus40.readdata;
      default: return bus16.readdata;
    endcase
  endfunction

  task automatic wr(int d, logic [2:0] a, logic [31:0] wd);
    drive(d, a, 1'b1, 1'b0, wd);
    @(posedge clk); #1;
    drive(d, 3'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic rd(int d, logic [2:0] a, logic [31:0] exp,
                    string name);
    logic [31:0] got;
    sb.push_back(exp);
    drive(d, a, 1'b1, 1'b1, 32'd0);
    @(posedge clk); #1;
    got = rdata(d);
    drive(d, 3'd0, 1'b0, 1'b1, 32'd0);
    check(name, 64'(got), 64'(sb.pop_front()));
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_vecs[0] = '{3'd0, 32'd0,     "rst_status"};
    rst_vecs[1] = '{3'd1, 32'd0,     "rst_control"};
    rst_vecs[2] = '{3'd2, 32'd49999, "rst_period_l"};
    rst_vecs[3] = '{3'd3, 32'd0,     "rst_period_h"};
    rst_vecs[4] = '{3'd4, 32'd0,     "rst_snap_l"};
    rst_vecs[5] = '{3'd5, 32'd0,     "rst_snap_h"};
    rst_vecs[6] = '{3'd6, 32'd0,     "rst_prescale"};
    rst_vecs[7] = '{3'd7, 32'd0,     "rst_tocount"};

    reset_n = 1'b0;
    for (int d = 0; d < 3; d++)
      drive(d, 3'd0, 1'b0, 1'b1, 32'd0);
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_irq", 64'(irq), 64'd0);
    check("rst_pulse", 64'(tp), 64'd0);
    for (int i = 0; i < 8; i++)
      rd(0, rst_vecs[i].addr, rst_vecs[i].exp, rst_vecs[i].name);

    // Continuous 5-clock timeouts with pulse and irq.
    wr(0, 3'd2, 32'd4);
    wr(0, 3'd6, 32'd0);
    wr(0, 3'd1, 32'h13);
    wr(0, 3'd1, 32'h17);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      check($sformatf("cont_pulse_%0d", i), 64'(tp),
            64'((i % 5) == 0));
      check($sformatf("cont_irq_%0d", i), 64'(irq),
            64'(i >= 5));
    end
    rd(0, 3'd7, 32'd3, "cont_tocount");
    wr(0, 3'd1, 32'h08);
    wr(0, 3'd0, 32'd0);
    wr(0, 3'd7, 32'd0);

    // One-shot with prescale 3: (2+1)*(3+1) = 12 clocks.
    wr(0, 3'd2, 32'd2);
    wr(0, 3'd6, 32'd3);
    wr(0, 3'd1, 32'h05);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      check($sformatf("oneshot_irq_%0d", i), 64'(irq),
            64'(i >= 12));
      check($sformatf("oneshot_pulse_%0d", i), 64'(tp), 64'd0);
    end
    rd(0, 3'd0, 32'd1, "oneshot_status");
    wr(0, 3'd4, 32'd0);
    rd(0, 3'd4, 32'd2, "oneshot_counter");
    rd(0, 3'd7, 32'd1, "oneshot_tocount");
    wr(0, 3'd0, 32'd0);
    rd(0, 3'd0, 32'd0, "oneshot_to_clr");
    check("oneshot_irq_clr", 64'(irq), 64'd0);

    // Stop after 10 clocks, hold, resume.
    wr(0, 3'd2, 32'd100);
    wr(0, 3'd6, 32'd0);
    wr(0, 3'd1, 32'h06);
    cycles(9);
    wr(0, 3'd1, 32'h0A);
    wr(0, 3'd4, 32'd0);
    rd(0, 3'd4, 32'd90, "stop_snap");
    cycles(5);
    wr(0, 3'd5, 32'd0);
    rd(0, 3'd4, 32'd90, "stop_hold");
    rd(0, 3'd5, 32'd0, "snap_h_32");
    wr(0, 3'd1, 32'h06);
    cycles(4);
    wr(0, 3'd4, 32'd0);
    rd(0, 3'd4, 32'd86, "resume_snap");
    wr(0, 3'd1, 32'h0A);

    // Clears coinciding with timeout events.
    wr(0, 3'd2, 32'd3);
    wr(0, 3'd0, 32'd0);
    wr(0, 3'd1, 32'h06);
    cycles(3);
    wr(0, 3'd0, 32'd0);
    rd(0, 3'd0, 32'd3, "to_set_wins");
    cycles(2);
    wr(0, 3'd7, 32'd0);
    rd(0, 3'd7, 32'd1, "tocount_set_wins");
    wr(0, 3'd1, 32'h0A);
    wr(0, 3'd1, 32'h0E);
    rd(0, 3'd0, 32'd3, "start_stop_run");
    rd(0, 3'd1, 32'd2, "ctrl_strobes_rd0");

    // Asynchronous reset mid-count.
    wr(0, 3'd1, 32'h07);
    check("pre_rst_irq", 64'(irq), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_rdata", 64'(bus.readdata), 64'd0);
    check("async_rst_irq", 64'(irq), 64'd0);
    check("async_rst_pulse", 64'(tp), 64'd0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_irq", 64'(irq), 64'd0);
    check("post_rst_pulse", 64'(tp), 64'd0);
    rd(0, 3'd2, 32'd49999, "post_rst_period");
    rd(0, 3'd0, 32'd0, "post_rst_status");

    // 40-bit build: high word reload and snapshot.
    wr(1, 3'd3, 32'd1);
    wr(1, 3'd2, 32'd0);
    wr(1, 3'd4, 32'd0);
    rd(1, 3'd5, 32'd1, "w40_snap_h");
    rd(1, 3'd4, 32'd0, "w40_snap_l");
    rd(1, 3'd3, 32'd1, "w40_period_h");

    // 16-bit build: truncation, high word ignored.
    wr(2, 3'd2, 32'hABCD1234);
    rd(2, 3'd2, 32'h1234, "w16_period_l");
    wr(2, 3'd1, 32'h06);
    wr(2, 3'd3, 32'd5);
    rd(2, 3'd0, 32'd2, "w16_ph_no_reload");
    rd(2, 3'd3, 32'd0, "w16_period_h");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/avalon_param_interval_timer.md
Name: avalon_param_interval_timer

Overview:
Parametrised successor to the team's fixed 16-bit-bus interval timer, as an Avalon-MM slave with a 32-bit data bus. Adds a configurable counter width, a programmable prescaler, a timeout-pulse output and a saturating timeout counter. Sits on the control-plane interconnect next to the mSGDMA, providing periodic interrupts and timestamp snapshots.

Parameters:
COUNT_WIDTH, 32, counter/period/snapshot width; legal range 8..64.
RESET_PERIOD, 49999, reset value of the period and counter registers; must fit in COUNT_WIDTH.
PRESCALE_WIDTH, 8, width of the prescaler divider register; legal range 1..16.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
address  in  3  word address of the register.
chipselect  in  1  slave select.
write_n  in  1  active-low write; a write occurs when chipselect=1 and write_n=0.
writedata  in  32  write data.
readdata  out  32  registered read data; valid 1 cycle after address is presented.
irq  out  1  level interrupt = TO & ITO.
timeout_pulse  out  1  registered 1-cycle pulse on each timeout when PULSE_EN=1.

Behaviour:
- Reset: counter=RESET_PERIOD, period=RESET_PERIOD, prescale=0, prescale_cnt=0, CONTROL=0, TO=0, RUN=0, snapshot=0, tocount=0, readdata=0, timeout_pulse=0, irq=0.
- Register map:
  0 STATUS: bit0 TO (sticky), bit1 RUN. Any write clears TO.
  1 CONTROL: bit0 ITO, bit1 CONT, bit4 PULSE_EN are stored and read back. bit2 START and bit3 STOP are write-only strobes and read 0.
  2 PERIOD_L: period[31:0].
  3 PERIOD_H: period[COUNT_WIDTH-1:32]. If COUNT_WIDTH<=32, reads 0 and writes are ignored (no reload side effect).
  4 SNAP_L / 5 SNAP_H: a write to either captures the live counter into snapshot; reads return snapshot low/high. High word is 0 if COUNT_WIDTH<=32.
  6 PRESCALE: [PRESCALE_WIDTH-1:0] divider.
  7 TOCOUNT: [15:0] saturating timeout count; any write clears it.
- Unused read bits return 0. readdata is the registered read mux, latency 1, updated every cycle whether or not the slave is selected.
- Tick: while RUN=1, prescale_cnt counts 0..PRESCALE; tick=1 when prescale_cnt==PRESCALE, then prescale_cnt wraps to 0. PRESCALE=0 gives a tick every clock.
- Counting: on tick with counter!=0, counter decrements by 1. On tick with counter==0 (timeout event):
  - counter loads period;
  - TO set;
  - tocount increments, saturating at 0xFFFF;
  - timeout_pulse=1 on the next cycle if PULSE_EN=1;
  - if CONT=0, RUN clears.
- Timeout period is therefore (period+1)*(PRESCALE+1) clocks.
- Period write (any implemented PERIOD word): on the next cycle, counter loads the new period, RUN clears and prescale_cnt clears. Partial 64-bit updates take effect immediately; software writes L then H.
- START strobe: sets RUN. If RUN was 0, prescale_cnt also clears. If already running, START has no effect on the count.
- STOP strobe: clears RUN. The counter holds its value and resumes on the next START.
- START and STOP in the same write: START wins.
- TO clear in the same cycle as a timeout event: set wins. The same rule applies to a TOCOUNT clear coinciding with an event, which results in tocount=1.
- Period write coinciding with a timeout event: the reload with the new period and RUN=0 take priority.
- Snapshot captures the counter value present in the cycle of the write.
- Reset asserted mid-count returns all state to reset values immediately (asynchronous); no pulse or irq glitch after deassertion.

Test Plan:
- Reset, then read addresses 0..7 -> STATUS=0, CONTROL=0, PERIOD_L=49999, PERIOD_H=0, SNAP=0, PRESCALE=0, TOCOUNT=0; irq=0.
- PERIOD_L=4, PRESCALE=0, CONTROL=0x13 (ITO|CONT|PULSE_EN), then START -> timeout every 5 clocks; timeout_pulse 1 cycle wide each; irq high after first timeout; TOCOUNT=3 after 15 clocks.
- PERIOD_L=2, PRESCALE=3, CONT=0, START -> single timeout after 12 clocks; RUN=0 afterwards, counter=2, TO=1; write STATUS -> TO=0, irq=0.
- Running with PERIOD=100, STOP after 10 clocks -> snapshot reads 90±1 (exact per cycle model); counter holds; START resumes the decrement from the same value.
- Write STATUS in the exact cycle of a timeout event -> TO remains 1. Write START|STOP together -> RUN=1.
- COUNT_WIDTH=40: PERIOD_H=0x1, PERIOD_L=0 -> SNAP_H reads 0x1 right after reload; COUNT_WIDTH=16 build: PERIOD_H write ignored, reads 0.
